// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host blocks: transmitter FSM states,
// common command/response bytes and default timing at a 50 MHz system clock.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    XFER,
    WAIT_IDLE,
    DONE
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;
  localparam int DEF_MAX_RETRIES    = 2;

  // Frame positions counted in device clock falls after the request.
  localparam logic [3:0] LAST_DATA_BIT = 4'd7;
  localparam logic [3:0] PARITY_BIT    = 4'd8;
  localparam logic [3:0] STOP_BIT      = 4'd9;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a one-cycle
// pulse on each synchronized clock fall; shared by host transmitter and receiver.
`timescale 1ns/1ps
module ps2_sync_edge (
  input  logic clk,
  input  logic clrn,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic data_meta;
  logic clk_prev;

  // Idle PS/2 lines are high, so reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      clk_prev  <= 1'b1;
    end else begin
      clk_meta  <= clk_pin;
      clk_sync  <= clk_meta;
      data_meta <= data_pin;
      data_sync <= data_meta;
      clk_prev  <= clk_sync;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain pull-low enables.
// Optional automatic retry on NACK/timeout is enabled with PS2_TX_RETRY_EN.
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
`ifdef PS2_TX_RETRY_EN
  ,
  output logic [1:0] retry_cnt
`endif
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int RETRY_LIMIT = RETRY_EN ? MAX_RETRIES : 0;

  tx_state_t     state;
  logic [7:0]    tx_byte;
  logic          par;
  logic          ack_seen;
  logic [3:0]    bit_idx;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    retry_q;
  logic          clk_s;
  logic          data_s;
  logic          clk_fall;
  logic          attempt_failed;
  logic          retry_left;

  ps2_sync_edge u_sync (
    .clk       (clk),
    .clrn      (clrn),
    .clk_pin   (ps2_clk_in),
    .data_pin  (ps2_data_in),
    .clk_sync  (clk_s),
    .data_sync (data_s),
    .clk_fall  (clk_fall)
  );

  // A timeout while clocking, or a NACK once the bus has gone idle again.
  assign attempt_failed = ((state == XFER) && (tmo_cnt == TMO_LAST)) ||
                          ((state == WAIT_IDLE) && clk_s && data_s && !ack_seen);
  assign retry_left = (RETRY_LIMIT != 0) && (retry_q != 2'(RETRY_LIMIT));

`ifdef PS2_TX_RETRY_EN
  assign retry_cnt = retry_q;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      tx_byte     <= '0;
      par         <= 1'b0;
      ack_seen    <= 1'b0;
      bit_idx     <= '0;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      retry_q     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (attempt_failed) begin
        ps2_data_oe <= 1'b0;
        if (retry_left) begin
          retry_q    <= retry_q + 2'd1;
          ps2_clk_oe <= 1'b1;
          inh_cnt    <= '0;
          state      <= INHIBIT;
        end else begin
          ps2_clk_oe <= 1'b0;
          ack_ok     <= 1'b0;
          err        <= 1'b1;
          done       <= 1'b1;
          state      <= DONE;
        end
      end else begin
        case (state)
          IDLE: begin
            if (send) begin
              tx_byte    <= tx_data;
              par        <= odd_parity(tx_data);
              busy       <= 1'b1;
              ack_ok     <= 1'b0;
              err        <= 1'b0;
              retry_q    <= '0;
              inh_cnt    <= '0;
              ps2_clk_oe <= 1'b1;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b1;
              tmo_cnt     <= '0;
              state       <= REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          REQ: begin
            bit_idx <= '0;
            tmo_cnt <= tmo_cnt + 1'b1;
            state   <= XFER;
          end
          XFER: begin
            tmo_cnt <= tmo_cnt + 1'b1;
            // Host changes data on device clock falls; the device samples on rises.
            if (clk_fall) begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx <= LAST_DATA_BIT) begin
                ps2_data_oe <= ~tx_byte[bit_idx[2:0]];
              end else if (bit_idx == PARITY_BIT) begin
                ps2_data_oe <= ~par;
              end else if (bit_idx == STOP_BIT) begin
                ps2_data_oe <= 1'b0;
              end else begin
                ack_seen <= ~data_s;
                state    <= WAIT_IDLE;
              end
            end
          end
          WAIT_IDLE: begin
            if (clk_s && data_s) begin
              ack_ok <= 1'b1;
              err    <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
